// File: rtl/tl_light_monitor.sv
// tl_light_monitor: receive-side protocol checker for the traffic-light
// controller. It decodes the La/Lb light buses back to the controller state,
// tracks how long each state is held, counts legal state changes and raises
// sticky flags for illegal patterns, illegal transitions and long yellows.
module tl_light_monitor #(
    parameter int unsigned YEL_MAX = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       La,
    input  logic [1:0]       Lb,
    input  logic             clr_err,
    output logic [1:0]       q,
    output logic             q_valid,
    output logic [CNT_W-1:0] dwell,
    output logic [7:0]       change_cnt,
    output logic             err_enc,
    output logic             err_trans,
    output logic             err_yel,
    output logic             err_any
);

    localparam int unsigned STATE_W  = 2;
    localparam int unsigned LIGHT_W  = 2;
    localparam int unsigned CHANGE_W = 8;

    // Light codes on each street bus.
    localparam logic [LIGHT_W-1:0] L_GREEN  = 2'b00;
    localparam logic [LIGHT_W-1:0] L_YELLOW = 2'b01;
    localparam logic [LIGHT_W-1:0] L_RED    = 2'b10;

    // Controller states; the legal cycle is S0->S1->S2->S3->S0 (increment).
    localparam logic [STATE_W-1:0] S0 = 2'b00;
    localparam logic [STATE_W-1:0] S1 = 2'b01;
    localparam logic [STATE_W-1:0] S2 = 2'b10;
    localparam logic [STATE_W-1:0] S3 = 2'b11;

    // Dwell limits. A yellow limit beyond the counter range can never trip.
    localparam logic [CNT_W-1:0]   DWELL_MAX     = '1;
    localparam logic [CNT_W-1:0]   DWELL_ONE     = CNT_W'(1);
    localparam longint unsigned    DWELL_TOP     = (64'd1 << CNT_W) - 64'd1;
    localparam bit                 YEL_REACHABLE = (64'(YEL_MAX) + 64'd1) <= DWELL_TOP;
    localparam logic [CNT_W-1:0]   YEL_LIMIT     = CNT_W'(YEL_MAX + 1);

    typedef enum logic {
        MON_INIT  = 1'b0,
        MON_TRACK = 1'b1
    } mon_state_t;

    mon_state_t mon_state;
    mon_state_t mon_state_nxt;

    logic               dec_valid;
    logic [STATE_W-1:0] dec_state;
    logic               trans_legal;

    logic [STATE_W-1:0]  q_nxt;
    logic                q_valid_nxt;
    logic [CNT_W-1:0]    dwell_nxt;
    logic [CHANGE_W-1:0] change_nxt;
    logic                dwell_step;
    logic                enc_hit;
    logic                trans_hit;
    logic                yel_hit;
    logic                err_enc_nxt;
    logic                err_trans_nxt;
    logic                err_yel_nxt;

    // Yellow phases are S1 and S3, both with the low state bit set.
    function automatic logic is_yellow(input logic [STATE_W-1:0] s);
        return s[0];
    endfunction

    // Decode the light pair back to a controller state.
    always_comb begin
        dec_valid = 1'b0;
        dec_state = S0;
        if (La == L_GREEN && Lb == L_RED) begin
            dec_valid = 1'b1;
            dec_state = S0;
        end else if (La == L_YELLOW && Lb == L_RED) begin
            dec_valid = 1'b1;
            dec_state = S1;
        end else if (La == L_RED && Lb == L_GREEN) begin
            dec_valid = 1'b1;
            dec_state = S2;
        end else if (La == L_RED && Lb == L_YELLOW) begin
            dec_valid = 1'b1;
            dec_state = S3;
        end
    end

    // A change is legal only when it steps to the next state in the cycle.
    always_comb begin
        trans_legal = (dec_state == STATE_W'(q + STATE_W'(1)));
    end

    // Monitor state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mon_state <= MON_INIT;
        end else begin
            mon_state <= mon_state_nxt;
        end
    end

    // Next monitor state: an illegal pattern drops the reference state.
    always_comb begin
        mon_state_nxt = mon_state;
        if (!dec_valid) begin
            mon_state_nxt = MON_INIT;
        end else begin
            mon_state_nxt = MON_TRACK;
        end
    end

    // Next values of the decoded state, counters and error events.
    always_comb begin
        q_nxt       = q;
        q_valid_nxt = q_valid;
        dwell_nxt   = dwell;
        change_nxt  = change_cnt;
        dwell_step  = 1'b0;
        enc_hit     = 1'b0;
        trans_hit   = 1'b0;
        yel_hit     = 1'b0;

        if (!dec_valid) begin
            enc_hit     = 1'b1;
            q_valid_nxt = 1'b0;
            dwell_nxt   = '0;
        end else begin
            unique case (mon_state)
                MON_INIT: begin
                    q_nxt       = dec_state;
                    q_valid_nxt = 1'b1;
                    dwell_nxt   = DWELL_ONE;
                    dwell_step  = 1'b1;
                end
                MON_TRACK: begin
                    q_valid_nxt = 1'b1;
                    if (dec_state == q) begin
                        if (dwell != DWELL_MAX) begin
                            dwell_nxt  = dwell + DWELL_ONE;
                            dwell_step = 1'b1;
                        end
                    end else begin
                        q_nxt      = dec_state;
                        dwell_nxt  = DWELL_ONE;
                        dwell_step = 1'b1;
                        if (trans_legal) begin
                            change_nxt = change_cnt + CHANGE_W'(1);
                        end else begin
                            trans_hit = 1'b1;
                        end
                    end
                end
                default: begin
                    q_valid_nxt = 1'b0;
                end
            endcase

            // Flag only on the edge where the yellow dwell reaches the limit.
            if (YEL_REACHABLE && dwell_step && is_yellow(q_nxt) &&
                dwell_nxt == YEL_LIMIT) begin
                yel_hit = 1'b1;
            end
        end
    end

    // Sticky flags: a new error in the clearing cycle wins over clr_err.
    always_comb begin
        err_enc_nxt   = enc_hit   | (err_enc   & ~clr_err);
        err_trans_nxt = trans_hit | (err_trans & ~clr_err);
        err_yel_nxt   = yel_hit   | (err_yel   & ~clr_err);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            q          <= S0;
            q_valid    <= 1'b0;
            dwell      <= '0;
            change_cnt <= '0;
            err_enc    <= 1'b0;
            err_trans  <= 1'b0;
            err_yel    <= 1'b0;
            err_any    <= 1'b0;
        end else begin
            q          <= q_nxt;
            q_valid    <= q_valid_nxt;
            dwell      <= dwell_nxt;
            change_cnt <= change_nxt;
            err_enc    <= err_enc_nxt;
            err_trans  <= err_trans_nxt;
            err_yel    <= err_yel_nxt;
            err_any    <= err_enc_nxt | err_trans_nxt | err_yel_nxt;
        end
    end

endmodule

// File: tb/tb_tl_light_monitor.sv
// Directed bench for tl_light_monitor; a second instance with a 2-bit dwell
// counter shares the stimulus to exercise dwell saturation.
module tb_tl_light_monitor;

    logic       clk;
    logic       reset;
    logic [1:0] La;
    logic [1:0] Lb;
    logic       clr_err;

    logic [1:0] q,   q2;
    logic       q_valid, q_valid2;
    logic [7:0] dwell;
    logic [1:0] dwell2;
    logic [7:0] change_cnt, change_cnt2;
    logic       err_enc, err_trans, err_yel, err_any;
    logic       err_enc2, err_trans2, err_yel2, err_any2;

    int n_chk;
    int n_pass;

    tl_light_monitor #(.YEL_MAX(1), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .La(La), .Lb(Lb), .clr_err(clr_err),
        .q(q), .q_valid(q_valid), .dwell(dwell), .change_cnt(change_cnt),
        .err_enc(err_enc), .err_trans(err_trans), .err_yel(err_yel), .err_any(err_any)
    );

    tl_light_monitor #(.YEL_MAX(1), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .La(La), .Lb(Lb), .clr_err(clr_err),
        .q(q2), .q_valid(q_valid2), .dwell(dwell2), .change_cnt(change_cnt2),
        .err_enc(err_enc2), .err_trans(err_trans2), .err_yel(err_yel2), .err_any(err_any2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic [1:0] eq, input logic ev,
                             input logic [7:0] ed, input logic [7:0] ec,
                             input logic een, input logic etr, input logic eyl);
        chk({tag, ".q"},          32'(q),          32'(eq));
        chk({tag, ".q_valid"},    32'(q_valid),    32'(ev));
        chk({tag, ".dwell"},      32'(dwell),      32'(ed));
        chk({tag, ".change_cnt"}, 32'(change_cnt), 32'(ec));
        chk({tag, ".err_enc"},    32'(err_enc),    32'(een));
        chk({tag, ".err_trans"},  32'(err_trans),  32'(etr));
        chk({tag, ".err_yel"},    32'(err_yel),    32'(eyl));
        chk({tag, ".err_any"},    32'(err_any),    32'(een | etr | eyl));
    endtask

    // Apply one light pair for one clock, then settle past the edge.
    task automatic step(input logic [1:0] la, input logic [1:0] lb, input logic clr);
        La      = la;
        Lb      = lb;
        clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] R = 2'b10;
    localparam logic [1:0] X = 2'b11;

    initial begin
        logic [1:0] la_seq [4];
        logic [1:0] lb_seq [4];
        la_seq[0] = G; lb_seq[0] = R;
        la_seq[1] = Y; lb_seq[1] = R;
        la_seq[2] = R; lb_seq[2] = G;
        la_seq[3] = R; lb_seq[3] = Y;

        n_chk   = 0;
        n_pass  = 0;
        reset   = 1'b1;
        La      = G;
        Lb      = R;
        clr_err = 1'b0;
        #2;

        // Reset state
        step(G, R, 1'b0);
        check_all("reset", 2'd0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("reset2.dwell", 32'(dwell2), 32'd0);
        reset = 1'b0;

        // Hold S0 for four cycles; the 2-bit instance saturates at 3
        step(G, R, 1'b0);
        check_all("s0_d1", 2'd0, 1'b1, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0);
        step(G, R, 1'b0);
        check_all("s0_d2", 2'd0, 1'b1, 8'd2, 8'd0, 1'b0, 1'b0, 1'b0);
        step(G, R, 1'b0);
        check_all("s0_d3", 2'd0, 1'b1, 8'd3, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("sat2.dwell3", 32'(dwell2), 32'd3);
        step(G, R, 1'b0);
        chk("s0_d4.dwell", 32'(dwell), 32'd4);
        chk("sat2.hold", 32'(dwell2), 32'd3);

        // Full legal cycle
        step(Y, R, 1'b0);
        check_all("to_s1", 2'd1, 1'b1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0);
        chk("sat2.reload", 32'(dwell2), 32'd1);
        step(R, G, 1'b0);
        check_all("to_s2", 2'd2, 1'b1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0);
        step(R, G, 1'b0);
        check_all("s2_d2", 2'd2, 1'b1, 8'd2, 8'd2, 1'b0, 1'b0, 1'b0);
        step(R, Y, 1'b0);
        check_all("to_s3", 2'd3, 1'b1, 8'd1, 8'd3, 1'b0, 1'b0, 1'b0);
        step(G, R, 1'b0);
        check_all("back_s0", 2'd0, 1'b1, 8'd1, 8'd4, 1'b0, 1'b0, 1'b0);

        // Illegal pattern inside S2, then recovery without counting a change
        step(Y, R, 1'b0);
        step(R, G, 1'b0);
        check_all("s2_again", 2'd2, 1'b1, 8'd1, 8'd6, 1'b0, 1'b0, 1'b0);
        step(X, R, 1'b0);
        check_all("enc_err", 2'd2, 1'b0, 8'd0, 8'd6, 1'b1, 1'b0, 1'b0);
        step(R, G, 1'b0);
        check_all("enc_recover", 2'd2, 1'b1, 8'd1, 8'd6, 1'b1, 1'b0, 1'b0);

        // Clear in a clean cycle
        step(R, G, 1'b1);
        check_all("clr_clean", 2'd2, 1'b1, 8'd2, 8'd6, 1'b0, 1'b0, 1'b0);

        // Illegal transitions S2->S0 and S0->S2, then a legal S2->S3
        step(G, R, 1'b0);
        check_all("trans_s2_s0", 2'd0, 1'b1, 8'd1, 8'd6, 1'b0, 1'b1, 1'b0);
        step(G, R, 1'b1);
        check_all("clr_trans", 2'd0, 1'b1, 8'd2, 8'd6, 1'b0, 1'b0, 1'b0);
        step(R, G, 1'b0);
        check_all("trans_s0_s2", 2'd2, 1'b1, 8'd1, 8'd6, 1'b0, 1'b1, 1'b0);
        step(R, Y, 1'b0);
        check_all("legal_s3", 2'd3, 1'b1, 8'd1, 8'd7, 1'b0, 1'b1, 1'b0);

        // Long yellow in S3
        step(R, Y, 1'b0);
        check_all("yel_s3", 2'd3, 1'b1, 8'd2, 8'd7, 1'b0, 1'b1, 1'b1);
        step(G, R, 1'b1);
        check_all("clr_all", 2'd0, 1'b1, 8'd1, 8'd8, 1'b0, 1'b0, 1'b0);

        // Long yellow in S1 with clr_err in the same cycle: set wins
        step(Y, R, 1'b0);
        check_all("s1_d1", 2'd1, 1'b1, 8'd1, 8'd9, 1'b0, 1'b0, 1'b0);
        step(Y, R, 1'b1);
        check_all("yel_setwins", 2'd1, 1'b1, 8'd2, 8'd9, 1'b0, 1'b0, 1'b1);
        step(Y, R, 1'b0);
        check_all("yel_hold", 2'd1, 1'b1, 8'd3, 8'd9, 1'b0, 1'b0, 1'b1);

        // clr_err with an illegal pattern: err_enc still sets
        step(X, X, 1'b1);
        check_all("enc_setwins", 2'd1, 1'b0, 8'd0, 8'd9, 1'b1, 1'b0, 1'b0);

        // Re-acquire in S0 (no count), then build S2 with dwell 5 and err_trans
        step(G, R, 1'b0);
        check_all("init_s0", 2'd0, 1'b1, 8'd1, 8'd9, 1'b1, 1'b0, 1'b0);
        step(R, G, 1'b0);
        for (int i = 0; i < 4; i++) step(R, G, 1'b0);
        check_all("s2_d5", 2'd2, 1'b1, 8'd5, 8'd9, 1'b1, 1'b1, 1'b0);

        // Mid-sequence reset
        reset = 1'b1;
        step(R, G, 1'b0);
        check_all("mid_reset", 2'd0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // 256 legal changes wrap change_cnt to zero
        step(G, R, 1'b0);
        check_all("wrap_start", 2'd0, 1'b1, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 255; k++) step(la_seq[k % 4], lb_seq[k % 4], 1'b0);
        check_all("wrap_255", 2'd3, 1'b1, 8'd1, 8'd255, 1'b0, 1'b0, 1'b0);
        step(G, R, 1'b0);
        check_all("wrap_0", 2'd0, 1'b1, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("wrap2.change_cnt", 32'(change_cnt2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
